// File: rtl/simmem_pkg.sv
// Shared widths and payload types for the simulated-memory lane responder.
package simmem_pkg;

    localparam int unsigned SIMMEM_DATA_WIDTH    = 64;
    localparam int unsigned SIMMEM_LOGSIZE_WIDTH = 4;
    localparam int unsigned SIMMEM_MAX_LANES     = 16;
    localparam int unsigned SIMMEM_LANE_WIDTH    = $clog2(SIMMEM_MAX_LANES);

    typedef struct packed {
        logic                         is_store;
        logic                         err;
        logic [SIMMEM_DATA_WIDTH-1:0] data;
    } resp_t;

    typedef struct packed {
        logic                         valid;
        logic [SIMMEM_LANE_WIDTH-1:0] lane;
        resp_t                        resp;
    } pipe_t;

endpackage

// File: rtl/simmem_resp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is accepted only alongside a pop.
module simmem_resp_fifo
    import simmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  resp_t         push_data,
    input  logic          pop,
    output resp_t         head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    resp_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/simmem_lane_responder.sv
// Multi-lane memory responder: round-robin arbitration onto a shared word store,
// fixed-latency pipeline into per-lane response FIFOs. Optional SIMMEM_STATS_EN adds counters.
module simmem_lane_responder
    import simmem_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned DATA_WIDTH    = SIMMEM_DATA_WIDTH,
    parameter int unsigned LOGSIZE_WIDTH = SIMMEM_LOGSIZE_WIDTH,
    parameter int unsigned MEM_DEPTH     = 256,
    parameter int unsigned LATENCY       = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               a_valid,
    output logic [NUM_LANES-1:0]               a_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
    input  logic [NUM_LANES-1:0]               a_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
    output logic [NUM_LANES-1:0]               d_valid,
    input  logic [NUM_LANES-1:0]               d_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
    output logic [NUM_LANES-1:0]               d_is_store,
    output logic [NUM_LANES-1:0]               d_error
`ifdef SIMMEM_STATS_EN
    ,
    output logic [31:0]                        stat_reads,
    output logic [31:0]                        stat_writes,
    output logic [15:0]                        stat_errors
`endif
);

    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W   = $clog2(BYTES);
    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned ADDR_HI = OFF_W + IDX_W;
    localparam int unsigned LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NREG    = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [LW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         credit_q [NUM_LANES];
    logic [CW-1:0]         credit_d [NUM_LANES];
    pipe_t                 pipe_q   [NREG];
    pipe_t                 pipe_d   [NREG];
    logic [DATA_WIDTH-1:0] mem_q    [MEM_DEPTH];

    logic                     gnt_any;
    logic [LW-1:0]            gnt_lane;
    logic [LW-1:0]            idx_l;
    int unsigned              idx;
    logic [DATA_WIDTH-1:0]    sel_addr, sel_data, rdata, wr_word;
    logic [OFF_W-1:0]         off;
    logic [IDX_W-1:0]         widx;
    logic [LOGSIZE_WIDTH-1:0] sz;
    logic                     sel_store, oor, err, wr_en;
    int unsigned              nbytes;
    pipe_t                    new_entry, push_entry;

    resp_t                 head     [NUM_LANES];
    logic [NUM_LANES-1:0]  empty, full, pop;
    logic [CW-1:0]         fcount   [NUM_LANES];

    // Round-robin pick of the first eligible lane at or after the pointer.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_lane = '0;
        idx      = 0;
        idx_l    = '0;
        a_ready  = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            idx_l = LW'(idx);
            if (!gnt_any && !reset && a_valid[idx_l] && (credit_q[idx_l] < CW'(FIFO_DEPTH))) begin
                gnt_any  = 1'b1;
                gnt_lane = idx_l;
            end
        end
        if (gnt_any) a_ready[gnt_lane] = 1'b1;
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_lane == LW'(NUM_LANES - 1)) ? '0 : gnt_lane + LW'(1);
    end

    // Decode, error check, memory read and byte-merged write word for the granted lane.
    always_comb begin
        sel_addr  = a_address[DATA_WIDTH*gnt_lane +: DATA_WIDTH];
        sel_data  = a_data[DATA_WIDTH*gnt_lane +: DATA_WIDTH];
        sz        = a_size[LOGSIZE_WIDTH*gnt_lane +: LOGSIZE_WIDTH];
        sel_store = a_is_store[gnt_lane];
        off       = sel_addr[OFF_W-1:0];
        widx      = sel_addr[ADDR_HI-1:OFF_W];
        oor       = |sel_addr[DATA_WIDTH-1:ADDR_HI];
        nbytes    = (32'(sz) >= 31) ? 32'hFFFF_FFFF : (32'd1 << sz);
        err       = oor || (32'(sz) >= 31) || ((32'(off) + nbytes) > BYTES);
        rdata     = mem_q[widx];
        wr_en     = gnt_any && sel_store && !err;
        wr_word   = rdata;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if ((b >= 32'(off)) && (b < 32'(off) + nbytes))
                wr_word[8*b +: 8] = sel_data[8*(b - 32'(off)) +: 8];
        end
        new_entry               = '0;
        new_entry.valid         = gnt_any;
        new_entry.lane          = SIMMEM_LANE_WIDTH'(gnt_lane);
        new_entry.resp.is_store = sel_store;
        new_entry.resp.err      = err;
        new_entry.resp.data     = (sel_store || err) ? '0 : SIMMEM_DATA_WIDTH'(rdata);
    end

    always_comb begin
        pipe_d[0] = new_entry;
        for (int unsigned k = 1; k < NREG; k++) pipe_d[k] = pipe_q[k-1];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign push_entry = new_entry;
        end else begin : g_latn
            assign push_entry = pipe_q[NREG-1];
        end
    endgenerate

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pop[i]      = d_ready[i] && !empty[i];
            credit_d[i] = credit_q[i] + CW'(gnt_any && (gnt_lane == LW'(i))) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) credit_q[i] <= '0;
            for (int unsigned k = 0; k < NREG; k++) pipe_q[k] <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < NUM_LANES; i++) credit_q[i] <= credit_d[i];
            for (int unsigned k = 0; k < NREG; k++) pipe_q[k] <= pipe_d[k];
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[widx] <= wr_word;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        simmem_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push_entry.valid && (push_entry.lane == SIMMEM_LANE_WIDTH'(i))),
            .push_data (push_entry.resp),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (fcount[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            d_valid[i]                       = !empty[i];
            d_is_store[i]                    = !empty[i] && head[i].is_store;
            d_error[i]                       = !empty[i] && head[i].err;
            d_data[DATA_WIDTH*i +: DATA_WIDTH] = empty[i] ? '0 : DATA_WIDTH'(head[i].data);
        end
    end

    logic unused_fifo_status;
    always_comb begin
        unused_fifo_status = ^full;
        for (int unsigned i = 0; i < NUM_LANES; i++) unused_fifo_status = unused_fifo_status ^ (^fcount[i]);
    end

`ifdef SIMMEM_STATS_EN
    logic [31:0] reads_q, reads_d, writes_q, writes_d;
    logic [15:0] errors_q, errors_d;

    // Saturating counters of granted requests.
    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        errors_d = errors_q;
        if (gnt_any && !sel_store && (reads_q != '1))  reads_d  = reads_q + 32'd1;
        if (gnt_any && sel_store && (writes_q != '1))  writes_d = writes_q + 32'd1;
        if (gnt_any && err && (errors_q != '1))        errors_d = errors_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            errors_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            errors_q <= errors_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_simmem_lane_responder.sv
// Bench for simmem_lane_responder: directed scenarios then random traffic against a byte-level model.
module tb_simmem_lane_responder;

    localparam int NL = 4;
    localparam int LAT = 4;
    localparam int FD = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      a_valid, a_ready, a_is_store;
    logic [255:0]    a_address, a_data;
    logic [15:0]     a_size;
    logic [3:0]      d_valid, d_ready, d_is_store, d_error;
    logic [255:0]    d_data;
`ifdef SIMMEM_STATS_EN
    logic [31:0]     stat_reads, stat_writes;
    logic [15:0]     stat_errors;
`endif

    simmem_lane_responder dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_address  (a_address),
        .a_is_store (a_is_store),
        .a_size     (a_size),
        .a_data     (a_data),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_data     (d_data),
        .d_is_store (d_is_store),
        .d_error    (d_error)
`ifdef SIMMEM_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
        .stat_errors(stat_errors)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          st;
        bit          err;
        logic [63:0] data;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ptr = 0;
    int          credit [NL];
    rsp_t        q [NL][$];
    logic [7:0]  mb [2048];
    int          last_grant;
    logic [3:0]  last_ready;
    logic [63:0] last_data [NL];
    logic        last_err [NL];
    logic        last_st [NL];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model: compare outputs at negedge, then advance.
    task automatic step();
        logic [3:0]  er;
        logic [63:0] addr, dat, word;
        int          g, sz, off, widx;
        bit          ev, st, err;
        rsp_t        r;
        @(negedge clock);
        g = -1;
        if (!reset) begin
            for (int k = 0; k < NL; k++) begin
                int l;
                l = (ptr + k) % NL;
                if (g < 0 && a_valid[l] && credit[l] < FD) g = l;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("a_ready", 64'(a_ready), 64'(er));
        last_ready = a_ready;
        for (int i = 0; i < NL; i++) begin
            ev = (q[i].size() > 0) && (q[i][0].due <= cyc);
            chk($sformatf("d_valid[%0d]", i), 64'(d_valid[i]), 64'(ev));
            if (ev) begin
                chk($sformatf("d_data[%0d]", i), d_data[64*i +: 64], q[i][0].data);
                chk($sformatf("d_is_store[%0d]", i), 64'(d_is_store[i]), 64'(q[i][0].st));
                chk($sformatf("d_error[%0d]", i), 64'(d_error[i]), 64'(q[i][0].err));
                if (d_ready[i]) begin
                    last_data[i] = d_data[64*i +: 64];
                    last_err[i]  = d_error[i];
                    last_st[i]   = d_is_store[i];
                    void'(q[i].pop_front());
                    credit[i]--;
                end
            end
        end
        if (g >= 0) begin
            addr = a_address[64*g +: 64];
            dat  = a_data[64*g +: 64];
            sz   = int'(a_size[4*g +: 4]);
            st   = a_is_store[g];
            off  = int'(addr % 8);
            widx = int'((addr / 8) % 256);
            err  = (addr >= 64'd2048) || (off + (1 << sz) > 8);
            for (int b = 0; b < 8; b++) word[8*b +: 8] = mb[widx*8 + b];
            r.due  = cyc + LAT;
            r.st   = st;
            r.err  = err;
            r.data = (st || err) ? 64'd0 : word;
            q[g].push_back(r);
            credit[g]++;
            ptr = (g + 1) % NL;
            if (st && !err)
                for (int b = 0; b < (1 << sz); b++) mb[widx*8 + off + b] = dat[8*b +: 8];
        end
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                q[i].delete();
                credit[i] = 0;
            end
            ptr = 0;
        end
        last_grant = g;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int ln, input bit st, input logic [63:0] addr, input int sz, input logic [63:0] dat);
        a_is_store[ln]       = st;
        a_address[64*ln +: 64] = addr;
        a_size[4*ln +: 4]    = 4'(sz);
        a_data[64*ln +: 64]  = dat;
    endtask

    task automatic send(input int ln, input bit st, input logic [63:0] addr, input int sz, input logic [63:0] dat);
        bit got;
        int n;
        got = 0;
        n = 0;
        set_lane(ln, st, addr, sz, dat);
        a_valid[ln] = 1'b1;
        while (!got && n < 100) begin
            step();
            got = (last_grant == ln);
            n++;
        end
        a_valid[ln] = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'd1);
    endtask

    task automatic drain();
        int n;
        bit busy;
        n = 0;
        busy = 1;
        while (busy && n < 300) begin
            busy = 0;
            for (int i = 0; i < NL; i++) if (q[i].size() > 0) busy = 1;
            if (busy) step();
            n++;
        end
        if (busy) chk("drain_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int n2;
        reset      = 1'b1;
        a_valid    = '0;
        a_is_store = '0;
        a_address  = '0;
        a_size     = '0;
        a_data     = '0;
        d_ready    = '1;
        for (int i = 0; i < NL; i++) credit[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        step();
        chk("rst_d_data", d_data[63:0], 64'd0);
        chk("rst_d_error", 64'(d_error), 64'd0);
        chk("rst_d_is_store", 64'(d_is_store), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        reset = 1'b0;

        // Zero the whole store so every later read is defined.
        for (int w = 0; w < 256; w++) send(0, 1'b1, 64'(w * 8), 3, 64'd0);
        drain();

        // Single-lane store then read, with explicit latency check.
        send(0, 1'b1, 64'h10, 3, 64'hDEADBEEFCAFEF00D);
        repeat (3) step();
        chk("store_lat_valid", 64'(d_valid[0]), 64'd1);
        chk("store_lat_is_store", 64'(d_is_store[0]), 64'd1);
        drain();
        send(0, 1'b0, 64'h10, 3, 64'd0);
        drain();
        chk("rd_dead_data", last_data[0], 64'hDEADBEEFCAFEF00D);
        chk("rd_dead_err", 64'(last_err[0]), 64'd0);

        // All lanes continuously valid after reset: strict 0,1,2,3 rotation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NL; i++) set_lane(i, 1'b0, 64'(i * 8), 3, 64'd0);
        a_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("rr_seq", 64'(last_grant), 64'(k % NL));
            chk("rr_onehot", 64'($onehot0(last_ready)), 64'd1);
        end
        a_valid = '0;
        drain();

        // Lane 2 backpressured: exactly FIFO_DEPTH accepts, then in-order drain.
        a_valid = 4'hF;
        d_ready = 4'b1011;
        n2 = 0;
        for (int k = 0; k < 24; k++) begin
            set_lane(2, 1'b0, 64'(8 * (k % 4)), 3, 64'd0);
            step();
            if (last_grant == 2) n2++;
        end
        chk("bp_lane2_accepts", 64'(n2), 64'(FD));
        chk("bp_lane2_ready", 64'(a_ready[2]), 64'd0);
        a_valid = '0;
        d_ready = '1;
        drain();

        // Sub-word store into a zero word.
        send(1, 1'b1, 64'h20, 3, 64'd0);
        send(1, 1'b1, 64'h23, 1, 64'hABCD);
        send(1, 1'b0, 64'h20, 3, 64'd0);
        drain();
        chk("subword_data", last_data[1], 64'h000000ABCD000000);

        // Out-of-range read and straddling store.
        send(3, 1'b0, 64'h800, 3, 64'd0);
        drain();
        chk("oor_err", 64'(last_err[3]), 64'd1);
        chk("oor_data", last_data[3], 64'd0);
        send(3, 1'b1, 64'h06, 2, 64'hFFFFFFFF);
        drain();
        chk("straddle_err", 64'(last_err[3]), 64'd1);
        send(3, 1'b0, 64'h00, 3, 64'd0);
        drain();
        chk("straddle_unchanged", last_data[3], 64'd0);

        // Reset with three reads in flight.
        for (int i = 0; i < NL; i++) set_lane(i, 1'b0, 64'h10, 3, 64'd0);
        a_valid = 4'b0111;
        repeat (3) step();
        a_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_d_valid", 64'(d_valid), 64'd0);
        a_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_credit_free", 64'(last_grant), 64'(k));
        end
        a_valid = '0;
        drain();
        send(1, 1'b0, 64'h10, 3, 64'd0);
        drain();
        chk("mem_persist", last_data[1], 64'hDEADBEEFCAFEF00D);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NL; i++) begin
                logic [63:0] addr;
                addr = 64'($urandom_range(0, 2047));
                if ($urandom_range(0, 15) == 0) addr[11 + $urandom_range(0, 40)] = 1'b1;
                set_lane(i, 1'($urandom_range(0, 1)), addr, $urandom_range(0, 4),
                         {32'($urandom), 32'($urandom)});
                d_ready[i] = ($urandom_range(0, 3) != 0);
            end
            a_valid = 4'($urandom_range(0, 15));
            step();
        end
        a_valid = '0;
        d_ready = '1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
